// File: rtl/osd_text_overlay_pkg.sv
// Shared constants, enable-FSM encoding and colour helper for the OSD
// text overlay.
//   CHAR_W / CHAR_H : glyph cell size in pixels
//   LAT             : clocks from input sampling edge to matching output edge
//   osd_state_e     : enable FSM states
//   dim50()         : halves each 8-bit channel of a packed {R,G,B} pixel
package osd_text_overlay_pkg;

    localparam int CHAR_W = 8;
    localparam int CHAR_H = 8;
    localparam int LAT    = 4;

    typedef enum logic {
        OSD_OFF = 1'b0,
        OSD_ON  = 1'b1
    } osd_state_e;

    // Shift the whole word, then clear the bit that leaked in from the
    // neighbouring channel.
    function automatic logic [23:0] dim50(input logic [23:0] rgb);
        return (rgb >> 1) & 24'h7F7F7F;
    endfunction

endpackage

// File: rtl/osd_text_overlay_if.sv
// Video/memory bundle between the timing generator, character RAM,
// font ROM, HDMI encoder and the OSD overlay.
//   hcount/vcount, de_in/hsync_in/vsync_in, rgb_in : incoming video
//   char_rdaddr -> char_q                           : char RAM read port (1 clk read)
//   font_rdaddr -> font_q                           : font ROM read port (1 clk read)
//   de_out/hsync_out/vsync_out, rgb_out             : outgoing video
// master = video source + memories, slave = overlay.
interface osd_text_overlay_if;

    logic [11:0] hcount;
    logic [11:0] vcount;
    logic        de_in;
    logic        hsync_in;
    logic        vsync_in;
    logic [23:0] rgb_in;
    logic [9:0]  char_rdaddr;
    logic [7:0]  char_q;
    logic [9:0]  font_rdaddr;
    logic [7:0]  font_q;
    logic        de_out;
    logic        hsync_out;
    logic        vsync_out;
    logic [23:0] rgb_out;

    modport master (
        output hcount, vcount, de_in, hsync_in, vsync_in, rgb_in,
        output char_q, font_q,
        input  char_rdaddr, font_rdaddr,
        input  de_out, hsync_out, vsync_out, rgb_out
    );

    modport slave (
        input  hcount, vcount, de_in, hsync_in, vsync_in, rgb_in,
        input  char_q, font_q,
        output char_rdaddr, font_rdaddr,
        output de_out, hsync_out, vsync_out, rgb_out
    );

endinterface

// File: rtl/osd_text_overlay_sync_delay.sv
// Fixed-depth shift register carrying the {de,hsync,vsync,rgb} timing
// word alongside the glyph lookup path.
//   clk, reset : pixel clock, synchronous active-high clear
//   i_d        : word entering the delay line
//   o_q        : word delayed by DEPTH clocks
module osd_text_overlay_sync_delay #(
    parameter int WIDTH = 27,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_sr [DEPTH];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_sr[i] <= '0;
            end
        end else begin
            r_sr[0] <= i_d;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                r_sr[i] <= r_sr[i-1];
            end
        end
    end

    assign o_q = r_sr[DEPTH-1];

endmodule

// File: rtl/osd_text_overlay.sv
// Renders the character RAM as an 8x8-font text window over live video.
//   clk        : pixel clock
//   reset      : synchronous, active-high
//   enable_osd : OSD on/off request, honoured only at frame start
//   vid        : video in/out, char RAM and font ROM read ports (slave)
// Every input sampled at edge k appears on the outputs at edge k+LAT.
// Glyph path: char_rdaddr (k) -> char_q (k+1) -> font_rdaddr (k+2)
// -> font_q (k+3) -> rgb_out (k+4).
module osd_text_overlay
    import osd_text_overlay_pkg::*;
#(
    parameter logic [11:0] OSD_X    = 12'd64,
    parameter logic [11:0] OSD_Y    = 12'd48,
    parameter int          COLS     = 32,
    parameter int          ROWS     = 32,
    parameter logic [23:0] FG_COLOR = 24'hFFFFFF
) (
    input  logic clk,
    input  logic reset,
    input  logic enable_osd,
    osd_text_overlay_if.slave vid
);

    localparam int COL_W = $clog2(COLS);
    localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int XW    = COL_W + 3;
    localparam int YW    = ROW_W + 3;

    // 13-bit window bounds so a window touching 4095 cannot wrap.
    localparam logic [12:0] X_LO = {1'b0, OSD_X};
    localparam logic [12:0] X_HI = X_LO + 13'(COLS * CHAR_W);
    localparam logic [12:0] Y_LO = {1'b0, OSD_Y};
    localparam logic [12:0] Y_HI = Y_LO + 13'(ROWS * CHAR_H);

    // ---------------- S0 combinational: window and address ----------------
    logic [12:0]      w_h13;
    logic [12:0]      w_v13;
    logic             w_in_win;
    logic [XW-1:0]    w_xoff;
    logic [YW-1:0]    w_yoff;
    logic [COL_W-1:0] w_col;
    logic [ROW_W-1:0] w_row;
    logic [9:0]       w_char_addr;

    assign w_h13    = {1'b0, vid.hcount};
    assign w_v13    = {1'b0, vid.vcount};
    assign w_in_win = (w_h13 >= X_LO) && (w_h13 < X_HI) &&
                      (w_v13 >= Y_LO) && (w_v13 < Y_HI);

    assign w_xoff      = XW'(vid.hcount - OSD_X);
    assign w_yoff      = YW'(vid.vcount - OSD_Y);
    assign w_col       = w_xoff[XW-1:3];
    assign w_row       = w_yoff[YW-1:3];
    assign w_char_addr = 10'(32'(w_row) * 32'(COLS) + 32'(w_col));

    // ---------------- Enable FSM ----------------
    osd_state_e r_state;
    osd_state_e w_state_nxt;
    logic       w_frame_start;
    logic       w_active;

    assign w_frame_start = (vid.hcount == '0) && (vid.vcount == '0) && vid.de_in;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= OSD_OFF;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // The frame-start pixel itself already follows the new decision, so the
    // whole frame (including a window at 0,0) is rendered consistently.
    always_comb begin
        w_state_nxt = r_state;
        w_active    = 1'b0;
        if (w_frame_start) begin
            w_state_nxt = enable_osd ? OSD_ON : OSD_OFF;
        end
        w_active = (w_state_nxt == OSD_ON);
    end

    // ---------------- Timing word delay line ----------------
    logic [26:0] w_dly;

    osd_text_overlay_sync_delay #(
        .WIDTH (27),
        .DEPTH (LAT)
    ) u_sync_delay (
        .clk   (clk),
        .reset (reset),
        .i_d   ({vid.de_in, vid.hsync_in, vid.vsync_in, vid.rgb_in}),
        .o_q   (w_dly)
    );

    // ---------------- Glyph pipeline registers ----------------
    logic        r_s0_win, r_s1_win, r_s2_win, r_s3_win;
    logic        r_s0_act, r_s1_act, r_s2_act, r_s3_act;
    logic [2:0]  r_s0_px,  r_s1_px,  r_s2_px,  r_s3_px;
    logic [2:0]  r_s0_line, r_s1_line;
    logic        r_s2_inv, r_s3_inv;
    logic [9:0]  r_char_rdaddr;
    logic [9:0]  r_font_rdaddr;
    logic        r_de_out;
    logic        r_hsync_out;
    logic        r_vsync_out;
    logic [23:0] r_rgb_out;

    // ---------------- Pixel select ----------------
    logic [2:0]  w_bit_sel;
    logic        w_pix;
    logic [23:0] w_rgb_nxt;

    // font_q bit7 is the leftmost pixel, so column px maps to bit 7-px.
    assign w_bit_sel = ~r_s3_px;
    assign w_pix     = vid.font_q[w_bit_sel] ^ r_s3_inv;

    always_comb begin
        w_rgb_nxt = w_dly[23:0];
        if (!w_dly[26]) begin
            w_rgb_nxt = '0;
        end else if (r_s3_act && r_s3_win) begin
            w_rgb_nxt = w_pix ? FG_COLOR : dim50(w_dly[23:0]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_s0_win      <= 1'b0;
            r_s1_win      <= 1'b0;
            r_s2_win      <= 1'b0;
            r_s3_win      <= 1'b0;
            r_s0_act      <= 1'b0;
            r_s1_act      <= 1'b0;
            r_s2_act      <= 1'b0;
            r_s3_act      <= 1'b0;
            r_s0_px       <= '0;
            r_s1_px       <= '0;
            r_s2_px       <= '0;
            r_s3_px       <= '0;
            r_s0_line     <= '0;
            r_s1_line     <= '0;
            r_s2_inv      <= 1'b0;
            r_s3_inv      <= 1'b0;
            r_char_rdaddr <= '0;
            r_font_rdaddr <= '0;
            r_de_out      <= 1'b0;
            r_hsync_out   <= 1'b0;
            r_vsync_out   <= 1'b0;
            r_rgb_out     <= '0;
        end else begin
            // S0: sample position, launch char RAM read.
            r_s0_win  <= w_in_win;
            r_s0_act  <= w_active;
            r_s0_px   <= w_xoff[2:0];
            r_s0_line <= w_yoff[2:0];
            if (w_in_win) begin
                r_char_rdaddr <= w_char_addr;
            end

            // S1: char RAM is reading.
            r_s1_win  <= r_s0_win;
            r_s1_act  <= r_s0_act;
            r_s1_px   <= r_s0_px;
            r_s1_line <= r_s0_line;

            // S2: char_q valid, launch font ROM read; bit 7 selects inverse.
            if (r_s1_win) begin
                r_font_rdaddr <= {vid.char_q[6:0], r_s1_line};
            end
            r_s2_win <= r_s1_win;
            r_s2_act <= r_s1_act;
            r_s2_px  <= r_s1_px;
            r_s2_inv <= vid.char_q[7];

            // S3: font ROM is reading.
            r_s3_win <= r_s2_win;
            r_s3_act <= r_s2_act;
            r_s3_px  <= r_s2_px;
            r_s3_inv <= r_s2_inv;

            // Output: font_q valid, timing word arrives from the delay line.
            r_de_out    <= w_dly[26];
            r_hsync_out <= w_dly[25];
            r_vsync_out <= w_dly[24];
            r_rgb_out   <= w_rgb_nxt;
        end
    end

    assign vid.char_rdaddr = r_char_rdaddr;
    assign vid.font_rdaddr = r_font_rdaddr;
    assign vid.de_out      = r_de_out;
    assign vid.hsync_out   = r_hsync_out;
    assign vid.vsync_out   = r_vsync_out;
    assign vid.rgb_out     = r_rgb_out;

endmodule

// File: tb/tb_osd_text_overlay.sv
// Directed bench for osd_text_overlay: a character RAM and font ROM model
// with 1-clock reads, a table of pixel vectors with hand-computed outputs,
// and hand sequences for enable timing, reset and RAM update.
module tb_osd_text_overlay;
    import osd_text_overlay_pkg::*;

    localparam logic [23:0] P  = 24'h804020;   // window background input
    localparam logic [23:0] D  = 24'h402010;   // P dimmed by half
    localparam logic [23:0] F  = 24'hFFFFFF;   // glyph colour
    localparam logic [23:0] Q  = 24'h123456;   // outside-window input

    typedef struct {
        logic        en;
        logic [11:0] h;
        logic [11:0] v;
        logic        de;
        logic        hs;
        logic        vs;
        logic [23:0] rgb;
        logic        chk;
        logic [26:0] exp;
    } vec_t;

    logic clk;
    logic reset;
    logic enable_osd;
    int   total;
    int   bad;

    vec_t tbl[$];
    vec_t hist[$];

    logic [7:0] cram  [1024];
    logic [7:0] fontm [1024];

    osd_text_overlay_if vif();

    osd_text_overlay #(
        .OSD_X    (12'd64),
        .OSD_Y    (12'd48),
        .COLS     (32),
        .ROWS     (32),
        .FG_COLOR (24'hFFFFFF)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable_osd (enable_osd),
        .vid        (vif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read memories: data follows the address by one clock.
    always @(posedge clk) begin
        vif.char_q <= cram[vif.char_rdaddr];
        vif.font_q <= fontm[vif.font_rdaddr];
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int h, input int v,
                         input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s h=%0d v=%0d got=%h want=%h", name, h, v, act, exp);
        end
    endtask

    task automatic add(input logic en, input int h, input int v,
                       input logic de, input logic hs, input logic vs,
                       input logic [23:0] rgb, input logic [23:0] erg);
        vec_t r;
        r.en  = en;
        r.h   = 12'(h);
        r.v   = 12'(v);
        r.de  = de;
        r.hs  = hs;
        r.vs  = vs;
        r.rgb = rgb;
        r.chk = 1'b1;
        r.exp = {de, hs, vs, erg};
        tbl.push_back(r);
    endtask

    function automatic vec_t mk(input logic en, input int h, input int v,
                                input logic [23:0] rgb, input logic [23:0] erg);
        vec_t r;
        r.en  = en;
        r.h   = 12'(h);
        r.v   = 12'(v);
        r.de  = 1'b1;
        r.hs  = 1'b0;
        r.vs  = 1'b0;
        r.rgb = rgb;
        r.chk = 1'b1;
        r.exp = {3'b100, erg};
        return r;
    endfunction

    function automatic vec_t idle();
        vec_t r;
        r.en  = 1'b0;
        r.h   = 12'd2000;
        r.v   = 12'd2000;
        r.de  = 1'b0;
        r.hs  = 1'b0;
        r.vs  = 1'b0;
        r.rgb = '0;
        r.chk = 1'b0;
        r.exp = '0;
        return r;
    endfunction

    // Drive one pixel; the output seen LAT clocks later belongs to it.
    task automatic step(input vec_t r);
        vec_t o;
        enable_osd   = r.en;
        vif.hcount   = r.h;
        vif.vcount   = r.v;
        vif.de_in    = r.de;
        vif.hsync_in = r.hs;
        vif.vsync_in = r.vs;
        vif.rgb_in   = r.rgb;
        @(posedge clk);
        #1;
        hist.push_back(r);
        if (hist.size() > LAT) begin
            o = hist.pop_front();
            if (o.chk) begin
                check("pixel", int'(o.h), int'(o.v),
                      {5'd0, vif.de_out, vif.hsync_out, vif.vsync_out, vif.rgb_out},
                      {5'd0, o.exp});
            end
        end
    endtask

    task automatic flush();
        for (int i = 0; i < LAT; i++) step(idle());
    endtask

    initial begin
        logic [7:0]  glyph_a [8];
        logic [7:0]  glyph_b [8];
        logic [7:0]  pat;
        logic [23:0] rr;

        total = 0;
        bad   = 0;
        glyph_a = '{8'h18, 8'h24, 8'h42, 8'h7E, 8'h42, 8'h42, 8'h42, 8'h00};
        glyph_b = '{8'h7C, 8'h42, 8'h42, 8'h7C, 8'h42, 8'h42, 8'h7C, 8'h00};
        for (int i = 0; i < 1024; i++) begin
            cram[i]  = 8'h00;
            fontm[i] = 8'h00;
        end
        for (int i = 0; i < 8; i++) begin
            fontm[{7'h41, 3'(i)}] = glyph_a[i];
            fontm[{7'h42, 3'(i)}] = glyph_b[i];
        end
        cram[0]  = 8'h41;   // row 0 col 0 : 'A'
        cram[1]  = 8'h42;   // row 0 col 1 : 'B'
        cram[31] = 8'hC1;   // row 0 col 31: inverse 'A'
        cram[32] = 8'hC1;   // row 1 col 0 : inverse 'A'

        reset        = 1'b1;
        enable_osd   = 1'b0;
        vif.hcount   = '0;
        vif.vcount   = '0;
        vif.de_in    = 1'b0;
        vif.hsync_in = 1'b0;
        vif.vsync_in = 1'b0;
        vif.rgb_in   = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_video", 0, 0,
              {5'd0, vif.de_out, vif.hsync_out, vif.vsync_out, vif.rgb_out}, 32'd0);
        check("reset_char_rdaddr", 0, 0, {22'd0, vif.char_rdaddr}, 32'd0);
        check("reset_font_rdaddr", 0, 0, {22'd0, vif.font_rdaddr}, 32'd0);
        reset = 1'b0;

        // ---------------- vector table ----------------
        add(1, 0, 0, 1, 0, 1, Q, Q);                 // frame start, OSD on
        add(1, 5, 0, 0, 1, 0, 24'hAABBCC, 24'h0);    // blanking: syncs only
        add(1, 63, 48, 1, 0, 0, P, P);               // left of window
        pat = 8'b0001_1000;                          // 'A' line 0
        for (int i = 0; i < 8; i++) add(1, 64 + i, 48, 1, 0, 0, P, pat[7-i] ? F : D);
        pat = 8'b0111_1100;                          // 'B' line 0
        for (int i = 0; i < 8; i++) add(1, 72 + i, 48, 1, 0, 0, P, pat[7-i] ? F : D);
        add(1, 65, 48, 1, 0, 0, 24'hFF0101, 24'h7F0000);
        add(1, 319, 48, 1, 0, 0, P, F);              // last column, inverse px7
        add(1, 320, 48, 1, 0, 0, P, P);              // right of window
        add(1, 73, 49, 1, 0, 0, P, F);               // 'B' line 1 px1
        add(1, 77, 49, 1, 0, 0, P, D);               // 'B' line 1 px5
        add(1, 78, 49, 1, 0, 0, P, F);               // 'B' line 1 px6
        pat = 8'b1110_0111;                          // inverse 'A' line 0
        for (int i = 0; i < 8; i++) add(1, 64 + i, 56, 1, 0, 0, P, pat[7-i] ? F : D);
        add(1, 64, 47, 1, 0, 0, P, P);               // above window
        add(1, 64, 304, 1, 0, 0, P, P);              // below window
        add(1, 64, 303, 1, 0, 0, P, D);              // last line, blank cell
        add(1, 70, 50, 0, 1, 0, P, 24'h0);           // de low inside window

        foreach (tbl[i]) step(tbl[i]);
        flush();

        // ---------------- addresses ----------------
        step(mk(1, 73, 49, P, F));
        check("char_rdaddr_c1", 73, 49, {22'd0, vif.char_rdaddr}, 32'd1);
        step(idle());
        step(idle());
        check("font_rdaddr_B1", 73, 49, {22'd0, vif.font_rdaddr}, 32'h211);
        step(mk(1, 64, 56, P, F));
        check("char_rdaddr_r1", 64, 56, {22'd0, vif.char_rdaddr}, 32'd32);
        flush();

        // ---------------- OSD off: bit-exact passthrough ----------------
        step(mk(0, 0, 0, Q, Q));
        for (int i = 0; i < 24; i++) begin
            rr = 24'($urandom);
            step(mk(0, 64 + i * 11, 48 + (i % 9), rr, rr));
        end
        flush();

        // ---------------- mid-frame enable waits for frame start ----------------
        step(mk(1, 5, 100, Q, Q));
        step(mk(1, 67, 48, P, P));
        step(mk(1, 0, 0, Q, Q));
        step(mk(1, 67, 48, P, F));
        step(mk(0, 64, 48, P, D));                   // mid-frame drop ignored
        flush();

        // ---------------- reset mid-line ----------------
        step(mk(1, 68, 48, P, F));
        flush();
        reset        = 1'b1;
        enable_osd   = 1'b1;
        vif.hcount   = 12'd69;
        vif.vcount   = 12'd48;
        vif.de_in    = 1'b1;
        vif.hsync_in = 1'b1;
        vif.vsync_in = 1'b1;
        vif.rgb_in   = P;
        @(posedge clk);
        #1;
        check("rst_video", 69, 48,
              {5'd0, vif.de_out, vif.hsync_out, vif.vsync_out, vif.rgb_out}, 32'd0);
        check("rst_char_rdaddr", 69, 48, {22'd0, vif.char_rdaddr}, 32'd0);
        check("rst_font_rdaddr", 69, 48, {22'd0, vif.font_rdaddr}, 32'd0);
        reset = 1'b0;
        hist.delete();
        for (int i = 0; i < 4; i++) begin
            step(mk(1, 64 + i, 48, P, P));
            check("rst_flush", 64 + i, 48,
                  {5'd0, vif.de_out, vif.hsync_out, vif.vsync_out, vif.rgb_out}, 32'd0);
        end
        step(mk(1, 68, 48, P, P));
        flush();
        step(mk(1, 0, 0, Q, Q));
        step(mk(1, 67, 48, P, F));
        flush();

        // ---------------- char RAM update shows in next frame ----------------
        step(mk(1, 313, 296, P, D));
        flush();
        cram[10'h3FF] = 8'h42;
        step(mk(1, 0, 0, Q, Q));
        step(mk(1, 313, 296, P, F));
        step(mk(1, 318, 296, P, D));
        step(mk(1, 312, 296, P, D));
        flush();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
